mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one muxnto1-style N:1 data mux between up to 16 requesters.
- Drives the mux select `sel` and a one-hot grant.
- Presents a valid/ready handshake toward the single downstream consumer.
- Each grant lasts for BURST accepted beats, then priority rotates to the next requester.

---
 rtl/mux_rr_if.sv | 15 +
 rtl/mux_rr_arbiter.sv | 74 +++++++
 tb/tb_mux_rr_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mux_rr_if.sv
// mux_rr_if: request/grant/handshake bundle between requesters, arbiter and downstream consumer
interface mux_rr_if #(
  parameter int N         = 8,
  parameter int Sel_Width = 3
);
  logic                 en;
  logic [N-1:0]         req;
  logic                 out_ready;
  logic [Sel_Width-1:0] sel;
  logic [N-1:0]         gnt;
  logic                 out_valid;
  logic                 last;
  modport master(output en, req, out_ready, input sel, gnt, out_valid, last);
  modport slave(input en, req, out_ready, output sel, gnt, out_valid, last);
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin burst arbiter driving a shared N:1 mux select and one-hot grant
module mux_rr_arbiter #(
  parameter int N         = 8,
  parameter int Sel_Width = 3,
  parameter int BURST     = 4
) (
  input logic     clk,
  input logic     rst,
  mux_rr_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int CW = BURST > 1 ? $clog2(BURST) : 1;
  state_t               state_q, state_d;
  logic [Sel_Width-1:0] ptr_q, ptr_d, sel_q, sel_d, pick;
  logic [N-1:0]         gnt_q, gnt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 found, last, rel;
  assign last          = state_q == GRANT && cnt_q == CW'(BURST - 1);
  assign rel           = (bus.out_ready && last) || !bus.req[sel_q];
  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.out_valid = state_q == GRANT;
  assign bus.last      = last;
  // first requester at or after ptr, wrapping modulo N
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && bus.req[(int'(ptr_q) + i) % N]) begin
        found = 1'b1;
        pick  = Sel_Width'((int'(ptr_q) + i) % N);
      end
    end
  end
  // next-state: issue grants from IDLE, count beats and release from GRANT
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (bus.en && found) begin
        state_d = GRANT;
        sel_d   = pick;
        gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick;
        cnt_d   = '0;
      end
    end else if (rel) begin
      state_d = IDLE;
      gnt_d   = '0;
      cnt_d   = '0;
      ptr_d   = sel_q == Sel_Width'(N - 1) ? '0 : sel_q + 1'b1;
    end else begin
      cnt_d = bus.out_ready ? cnt_q + 1'b1 : cnt_q;
    end
  end
  // state registers with immediate reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed stimulus with a cycle-level reference model and literal spot checks
module tb_mux_rr_arbiter;
  localparam int N = 8, SW = 3, B = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mux_rr_if #(.N(N), .Sel_Width(SW)) bus();
  mux_rr_arbiter #(.N(N), .Sel_Width(SW), .BURST(B)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, failures = 0;
  bit m_busy;
  int m_idx, m_beats, m_ptr;
  bit m_found;
  int beats, ng;
  int order[8];
  logic [N-1:0] prev;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic to_idle();
    bus.req = '0;
    step();
    step();
  endtask
  // reference: a grant is a run of up to B beats to one index, search restarts after the last granted index
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_idx = 0; m_beats = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (bus.en && bus.req != 0) begin
        m_found = 0;
        for (int k = 0; k < N; k++)
          if (!m_found && bus.req[(m_ptr + k) % N]) begin
            m_found = 1;
            m_idx = (m_ptr + k) % N;
          end
        m_busy = 1;
        m_beats = 0;
      end
    end else if ((bus.out_ready && m_beats == B - 1) || !bus.req[m_idx]) begin
      m_busy = 0;
      m_ptr = (m_idx + 1) % N;
    end else if (bus.out_ready) begin
      m_beats++;
    end
  end
  // compare every cycle mid-period against the model
  always @(negedge clk) begin
    chk("m_gnt", 32'(bus.gnt), m_busy ? (32'd1 << m_idx) : 32'd0);
    chk("m_sel", 32'(bus.sel), 32'(m_idx));
    chk("m_valid", 32'(bus.out_valid), 32'(m_busy));
    chk("m_last", 32'(bus.last), 32'(m_busy && m_beats == B - 1));
  end
  initial begin
    bus.en = 1'b1; bus.req = '0; bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.req = N'($urandom);
      step();
    end
    bus.req = 8'hFF;
    step();
    rst = 1'b1;
    #1;
    chk("rst_sel", 32'(bus.sel), 0);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_last", 32'(bus.last), 0);
    step();
    rst = 1'b0;
    bus.req = 8'h24;
    step();
    chk("rst_first", 32'(bus.gnt), 32'h04);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 8'hFF;
    beats = 0; ng = 0; prev = '0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (bus.out_valid && bus.out_ready) beats++;
      if (bus.gnt != 0 && prev == 0 && ng < 8) begin
        order[ng] = int'(bus.sel);
        ng++;
      end
      prev = bus.gnt;
    end
    chk("fair_beats", 32'(beats), 16);
    chk("fair_grants", 32'(ng), 8);
    for (int k = 0; k < 8; k++) chk("fair_order", 32'(order[k]), 32'(k));
    step();
    chk("fair_wrap", 32'(bus.gnt), 32'h01);
    to_idle();
    bus.req = 8'h08;
    step();
    chk("single_gnt", 32'(bus.gnt), 32'h08);
    chk("single_sel", 32'(bus.sel), 3);
    chk("single_last0", 32'(bus.last), 0);
    step();
    chk("single_last1", 32'(bus.last), 1);
    chk("single_gnt2", 32'(bus.gnt), 32'h08);
    step();
    chk("single_bubble", 32'(bus.gnt), 0);
    chk("single_bubble_v", 32'(bus.out_valid), 0);
    chk("single_sel_hold", 32'(bus.sel), 3);
    bus.req = 8'h18;
    step();
    chk("single_ptr4", 32'(bus.gnt), 32'h10);
    to_idle();
    bus.req = 8'h20;
    step();
    chk("bp_gnt", 32'(bus.gnt), 32'h20);
    step();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_hold_gnt", 32'(bus.gnt), 32'h20);
      chk("bp_hold_sel", 32'(bus.sel), 5);
      chk("bp_hold_last", 32'(bus.last), 1);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release", 32'(bus.gnt), 0);
    to_idle();
    bus.req = 8'h80;
    step();
    chk("ab_gnt", 32'(bus.gnt), 32'h80);
    chk("ab_sel", 32'(bus.sel), 7);
    bus.req = 8'h01;
    step();
    chk("ab_release", 32'(bus.gnt), 0);
    bus.req = 8'h81;
    step();
    chk("ab_wrap", 32'(bus.gnt), 32'h01);
    to_idle();
    bus.en = 1'b0;
    bus.req = 8'h04;
    step();
    chk("en_off0", 32'(bus.gnt), 0);
    step();
    chk("en_off1", 32'(bus.gnt), 0);
    bus.en = 1'b1;
    step();
    chk("en_on", 32'(bus.gnt), 32'h04);
    bus.en = 1'b0;
    step();
    chk("en_finish", 32'(bus.gnt), 32'h04);
    chk("en_finish_last", 32'(bus.last), 1);
    step();
    chk("en_done", 32'(bus.gnt), 0);
    step(); step();
    chk("en_no_regrant", 32'(bus.gnt), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
